// File: rtl/multi_input_gate_acc.sv
// multi_input_gate_acc: packet-wide XOR/NAND/NOR/XNOR reduction of WIDTH-bit beats with valid/ready on both sides.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_valid/o_ready/i_data/i_code/i_last input beat;
// o_valid/i_ready result handshake; o_f result, o_beats saturating beat count, o_ovf count saturated;
// o_ones total popcount, present only when MULTI_INPUT_GATE_ACC_POPCNT_EN is defined.
module multi_input_gate_acc #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    input  logic [1:0]       i_code,
    input  logic             i_last,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_f,
    output logic [CNT_W-1:0] o_beats,
    output logic             o_ovf
`ifdef MULTI_INPUT_GATE_ACC_POPCNT_EN
    ,
    output logic [CNT_W+$clog2(WIDTH+1)-1:0] o_ones
`endif
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    state_t state, state_d;
    logic [1:0] code_q, code_n;
    logic xor_acc, and_acc, or_acc, xor_n, and_n, or_n, f_q, ovf;
    logic [CNT_W-1:0] cnt;
    logic accept, first;
    assign accept  = i_valid & o_ready;
    assign first   = state == IDLE;
    assign o_ready = state != DONE;
    assign o_valid = state == DONE;
    assign o_f     = f_q;
    assign o_beats = cnt;
    assign o_ovf   = ovf;
    // The first beat of a packet loads the accumulators rather than folding into stale contents.
    assign code_n = first ? i_code : code_q;
    assign xor_n  = (~first & xor_acc) ^ (^i_data);
    assign and_n  = (first | and_acc) & (&i_data);
    assign or_n   = (~first & or_acc) | (|i_data);
    always_comb
        state_d = (state == DONE) ? (i_ready ? IDLE : DONE) :
                  (accept && i_last) ? DONE :
                  accept ? ACCUM : state;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            code_q  <= 2'b00;
            xor_acc <= 1'b0;
            and_acc <= 1'b0;
            or_acc  <= 1'b0;
            f_q     <= 1'b0;
            cnt     <= '0;
            ovf     <= 1'b0;
        end else begin
            state <= state_d;
            if (accept) begin
                code_q  <= code_n;
                xor_acc <= xor_n;
                and_acc <= and_n;
                or_acc  <= or_n;
                cnt     <= first ? CNT_W'(1) : cnt + CNT_W'(!(&cnt));
                ovf     <= ~first & (ovf | (&cnt));
                if (i_last)
                    f_q <= code_n == 2'b00 ? xor_n :
                           code_n == 2'b01 ? ~and_n :
                           code_n == 2'b10 ? ~or_n : ~xor_n;
            end
        end
    end
`ifdef MULTI_INPUT_GATE_ACC_POPCNT_EN
    localparam int PW = $clog2(WIDTH + 1);
    localparam int OW = CNT_W + PW;
    logic [PW-1:0] pop;
    logic [OW:0] ones_sum;
    logic [OW-1:0] ones;
    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH; i++) pop = pop + PW'(i_data[i]);
    end
    // One extra bit catches the carry so the total can clamp at all-ones.
    assign ones_sum = (first ? {(OW+1){1'b0}} : {1'b0, ones}) + (OW+1)'(pop);
    assign o_ones   = ones;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) ones <= '0;
        else if (accept) ones <= ones_sum[OW] ? {OW{1'b1}} : ones_sum[OW-1:0];
    end
`endif
endmodule

// File: tb/tb_multi_input_gate_acc.sv
// tb_multi_input_gate_acc: randomized and directed checks of multi_input_gate_acc against a packet-level model.
module tb_multi_input_gate_acc;
    localparam int WIDTH = 3;
    localparam int CNT_W = 2;
    localparam int MAXC = 3;
    localparam int MAXO = 15;
    logic clk = 0, rst_n = 0, i_valid = 0, i_last = 0, i_ready = 0;
    logic [2:0] i_data = 0;
    logic [1:0] i_code = 0;
    logic o_ready, o_valid, o_f, o_ovf;
    logic [1:0] o_beats;
`ifdef MULTI_INPUT_GATE_ACC_POPCNT_EN
    logic [3:0] o_ones;
`endif
    int checks = 0, errors = 0;
    bit rr = 0;

    multi_input_gate_acc #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_data(i_data), .i_code(i_code), .i_last(i_last), .o_valid(o_valid),
        .i_ready(i_ready), .o_f(o_f), .o_beats(o_beats), .o_ovf(o_ovf)
`ifdef MULTI_INPUT_GATE_ACC_POPCNT_EN
        , .o_ones(o_ones)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Packet-level model: totals over the whole packet, no per-beat state machine.
    int m_n = 0, m_tot = 0, e_f = 0, e_beats = 0, e_ovf = 0, e_ones = 0;
    bit m_all = 1, m_any = 0, m_valid = 0;
    logic [1:0] m_code = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 0;
            m_n = 0;
        end else if (m_valid) begin
            if (i_ready) m_valid = 0;
        end else if (i_valid) begin
            if (m_n == 0) begin
                m_code = i_code;
                m_tot = 0;
                m_all = 1;
                m_any = 0;
            end
            m_n++;
            m_tot += $countones(i_data);
            m_all = m_all && (i_data == 3'b111);
            m_any = m_any || (i_data != 3'b000);
            if (i_last) begin
                case (m_code)
                    2'd0: e_f = m_tot % 2;
                    2'd1: e_f = m_all ? 0 : 1;
                    2'd2: e_f = m_any ? 0 : 1;
                    default: e_f = 1 - m_tot % 2;
                endcase
                e_beats = m_n > MAXC ? MAXC : m_n;
                e_ovf = m_n > MAXC ? 1 : 0;
                e_ones = m_tot > MAXO ? MAXO : m_tot;
                m_valid = 1;
                m_n = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("valid", o_valid, m_valid);
        chk("ready", o_ready, m_valid ? 0 : 1);
        if (m_valid) begin
            chk("f", o_f, e_f);
            chk("beats", o_beats, e_beats);
            chk("ovf", o_ovf, e_ovf);
`ifdef MULTI_INPUT_GATE_ACC_POPCNT_EN
            chk("ones", o_ones, e_ones);
`endif
        end
    end

    always @(negedge clk) if (rr) i_ready = 1'($urandom_range(0, 1));

    task automatic beat(input logic [2:0] d, input logic [1:0] c, input logic l);
        int k;
        bit acc;
        i_valid = 1;
        i_data = d;
        i_code = c;
        i_last = l;
        for (k = 0; k < 100; k++) begin
            acc = o_ready;
            @(negedge clk);
            if (acc) break;
        end
        if (k == 100) chk("beat_timeout", 0, 1);
        i_valid = 0;
    endtask

    task automatic res(input string nm, input int f, input int b, input int ov, input int on);
        chk({nm, "_lat"}, o_valid, 1);
        chk({nm, "_f"}, o_f, f);
        chk({nm, "_beats"}, o_beats, b);
        chk({nm, "_ovf"}, o_ovf, ov);
        chk({nm, "_model_f"}, e_f, f);
        chk({nm, "_model_ones"}, e_ones, on);
`ifdef MULTI_INPUT_GATE_ACC_POPCNT_EN
        chk({nm, "_ones"}, o_ones, on);
`endif
        i_ready = 1;
        @(negedge clk);
        i_ready = 0;
        chk({nm, "_idle_valid"}, o_valid, 0);
        chk({nm, "_idle_ready"}, o_ready, 1);
    endtask

    initial begin
        int n;
        logic [1:0] c;
        repeat (2) @(negedge clk);
        chk("rst_valid", o_valid, 0);
        chk("rst_ready", o_ready, 1);
        chk("rst_f", o_f, 0);
        chk("rst_beats", o_beats, 0);
        chk("rst_ovf", o_ovf, 0);
        @(posedge clk);
        #2 rst_n = 1;
        @(negedge clk);
        beat(3'b101, 2'b00, 1);
        res("t1", 0, 1, 0, 2);
        beat(3'b110, 2'b11, 1);
        res("t2a", 1, 1, 0, 2);
        beat(3'b111, 2'b11, 1);
        res("t2b", 0, 1, 0, 3);
        beat(3'b111, 2'b01, 0);
        beat(3'b111, 2'b10, 0);
        beat(3'b110, 2'b10, 1);
        res("t3", 1, 3, 0, 8);
        beat(3'b000, 2'b10, 0);
        beat(3'b000, 2'b10, 1);
        res("t4a", 1, 2, 0, 0);
        beat(3'b000, 2'b10, 0);
        beat(3'b010, 2'b10, 1);
        res("t4b", 0, 2, 0, 1);
        beat(3'b011, 2'b00, 1);
        i_valid = 1;
        i_data = 3'b111;
        i_code = 2'b00;
        i_last = 1;
        repeat (5) begin
            chk("bp_valid", o_valid, 1);
            chk("bp_ready", o_ready, 0);
            chk("bp_f", o_f, 0);
            chk("bp_beats", o_beats, 1);
            @(negedge clk);
        end
        i_ready = 1;
        @(negedge clk);
        i_ready = 0;
        chk("bp_rel_valid", o_valid, 0);
        chk("bp_rel_ready", o_ready, 1);
        @(negedge clk);
        i_valid = 0;
        res("bp_held", 1, 1, 0, 3);
        repeat (4) beat(3'b111, 2'b00, 0);
        beat(3'b111, 2'b00, 1);
        res("t6", 1, 3, 1, 15);
        beat(3'b101, 2'b00, 0);
        beat(3'b101, 2'b00, 0);
        @(posedge clk);
        #2 rst_n = 0;
        @(negedge clk);
        chk("mid_rst_valid", o_valid, 0);
        chk("mid_rst_ready", o_ready, 1);
        chk("mid_rst_beats", o_beats, 0);
        @(posedge clk);
        #2 rst_n = 1;
        @(negedge clk);
        beat(3'b111, 2'b01, 1);
        res("t7", 0, 1, 0, 3);
        rr = 1;
        for (int p = 0; p < 150; p++) begin
            n = $urandom_range(1, 6);
            c = 2'($urandom);
            for (int j = 0; j < n; j++) begin
                if ($urandom_range(0, 3) == 0) @(negedge clk);
                beat(3'($urandom), j == 0 ? c : 2'($urandom), j == n - 1);
            end
        end
        rr = 0;
        i_ready = 1;
        repeat (10) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
